fft_peak_finder: RTL and testbench

- Sits directly upstream of note_lookup.
- Consumes one frame of streamed FFT magnitude beats and tracks the largest magnitude within a configurable bin window.
- At frame end, emits that bin's index with a one-cycle ready pulse; this drives note_lookup's bin_index/ready_in pair.
- Frames whose peak is below threshold, or whose framing is malformed, produce a status pulse instead of a ready pulse.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/peak_cmp.sv | 44 ++++
 rtl/fft_peak_finder.sv | 185 ++++++++++++++++++
 tb/tb_fft_peak_finder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : fft_pkg                                                         |
// | Purpose  : Shared FFT framing constants and peak-finder state encoding,    |
// |            common to fft_peak_finder and note_lookup.                      |
// | Contents : FFT_SIZE, MAG_WIDTH, BIN_WIDTH, MIN_BIN, MAX_BIN, peak_state_t  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package fft_pkg;

  localparam int FFT_SIZE  = 1024;
  localparam int MAG_WIDTH = 32;
  localparam int BIN_WIDTH = $clog2(FFT_SIZE);

  // Candidate window: skip DC and the mirrored upper half of the spectrum.
  localparam int MIN_BIN = 1;
  localparam int MAX_BIN = FFT_SIZE / 2 - 1;

  typedef enum logic [0:0] {
    SCAN   = 1'b0,
    RESYNC = 1'b1
  } peak_state_t;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/peak_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : peak_cmp                                                        |
// | Purpose  : Combinational qualify-and-compare for one magnitude beat:       |
// |            bin window check, threshold check, strict greater-than against  |
// |            the current best.                                               |
// | Ports    : i_bin        - bin index of the current beat                    |
// |            i_mag        - magnitude of the current beat                    |
// |            i_thr        - threshold in force for this beat                 |
// |            i_best_mag   - magnitude of the current best candidate          |
// |            i_best_valid - a best candidate exists in this frame            |
// |            o_take       - beat becomes the new best                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module peak_cmp #(
  parameter int BIN_WIDTH = fft_pkg::BIN_WIDTH,
  parameter int MAG_WIDTH = fft_pkg::MAG_WIDTH,
  parameter int MIN_BIN   = fft_pkg::MIN_BIN,
  parameter int MAX_BIN   = fft_pkg::MAX_BIN
) (
  input  logic [BIN_WIDTH-1:0] i_bin,
  input  logic [MAG_WIDTH-1:0] i_mag,
  input  logic [MAG_WIDTH-1:0] i_thr,
  input  logic [MAG_WIDTH-1:0] i_best_mag,
  input  logic                 i_best_valid,
  output logic                 o_take
);

  localparam logic [BIN_WIDTH-1:0] c_MIN_BIN = BIN_WIDTH'(MIN_BIN);
  localparam logic [BIN_WIDTH-1:0] c_MAX_BIN = BIN_WIDTH'(MAX_BIN);

  logic w_in_window;
  logic w_meets_thr;
  logic w_beats_best;

  assign w_in_window  = (i_bin >= c_MIN_BIN) && (i_bin <= c_MAX_BIN);
  assign w_meets_thr  = (i_mag >= i_thr);
  // Strictly greater: on a tie the earlier (lower) bin is kept.
  assign w_beats_best = !i_best_valid || (i_mag > i_best_mag);

  assign o_take = w_in_window && w_meets_thr && w_beats_best;

endmodule : peak_cmp
`default_nettype wire

// File: rtl/fft_peak_finder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_peak_finder                                                 |
// | Purpose  : Tracks the largest FFT magnitude inside a bin window over one   |
// |            streamed frame and reports its bin at frame end. Frames with no |
// |            qualifying bin or with bad framing produce status pulses.       |
// | Ports    : clk_in        - system clock                                    |
// |            rst_in        - asynchronous active-low reset                   |
// |            mag_data_in   - magnitude of current bin                        |
// |            mag_valid_in  - beat valid (no backpressure)                    |
// |            mag_last_in   - final beat of frame                             |
// |            threshold_in  - minimum peak, sampled on first beat of frame    |
// |            bin_index_out - winning bin, held until next ready pulse        |
// |            peak_mag_out  - winning magnitude, held with bin_index_out      |
// |            ready_out     - 1-cycle pulse, new peak on outputs              |
// |            no_peak_out   - 1-cycle pulse, no bin met threshold             |
// |            frame_err_out - 1-cycle pulse, framing error                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fft_peak_finder #(
  parameter int FFT_SIZE  = fft_pkg::FFT_SIZE,
  parameter int MAG_WIDTH = fft_pkg::MAG_WIDTH,
  parameter int BIN_WIDTH = $clog2(FFT_SIZE),
  parameter int MIN_BIN   = fft_pkg::MIN_BIN,
  parameter int MAX_BIN   = FFT_SIZE / 2 - 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [MAG_WIDTH-1:0] mag_data_in,
  input  logic                 mag_valid_in,
  input  logic                 mag_last_in,
  input  logic [MAG_WIDTH-1:0] threshold_in,
  output logic [BIN_WIDTH-1:0] bin_index_out,
  output logic [MAG_WIDTH-1:0] peak_mag_out,
  output logic                 ready_out,
  output logic                 no_peak_out,
  output logic                 frame_err_out
);

  import fft_pkg::*;

  localparam logic [BIN_WIDTH-1:0] c_LAST_BIN = BIN_WIDTH'(FFT_SIZE - 1);

  peak_state_t r_state;
  peak_state_t w_state_nxt;

  logic [BIN_WIDTH-1:0] r_cnt;
  logic [MAG_WIDTH-1:0] r_thr;
  logic [MAG_WIDTH-1:0] r_best_mag;
  logic [BIN_WIDTH-1:0] r_best_bin;
  logic                 r_best_valid;
  logic [BIN_WIDTH-1:0] r_bin_index;
  logic [MAG_WIDTH-1:0] r_peak_mag;
  logic                 r_ready;
  logic                 r_no_peak;
  logic                 r_frame_err;

  logic                 w_beat;
  logic                 w_first;
  logic                 w_at_end;
  logic [MAG_WIDTH-1:0] w_thr;
  logic                 w_best_valid_eff;
  logic                 w_take;
  logic                 w_new_valid;
  logic [MAG_WIDTH-1:0] w_new_mag;
  logic [BIN_WIDTH-1:0] w_new_bin;
  logic                 w_frame_end;
  logic                 w_err_early;
  logic                 w_err_missing;

  assign w_beat   = mag_valid_in && (r_state == SCAN);
  assign w_first  = (r_cnt == '0);
  assign w_at_end = (r_cnt == c_LAST_BIN);

  // The first beat of a frame opens a new search: thr_q is not loaded yet,
  // and any best left over from the previous frame must be ignored.
  assign w_thr            = w_first ? threshold_in : r_thr;
  assign w_best_valid_eff = w_first ? 1'b0 : r_best_valid;

  peak_cmp #(
    .BIN_WIDTH (BIN_WIDTH),
    .MAG_WIDTH (MAG_WIDTH),
    .MIN_BIN   (MIN_BIN),
    .MAX_BIN   (MAX_BIN)
  ) u_peak_cmp (
    .i_bin        (r_cnt),
    .i_mag        (mag_data_in),
    .i_thr        (w_thr),
    .i_best_mag   (r_best_mag),
    .i_best_valid (w_best_valid_eff),
    .o_take       (w_take)
  );

  // Best-so-far including the current beat, so the last beat counts too.
  assign w_new_valid = w_take || w_best_valid_eff;
  assign w_new_mag   = w_take ? mag_data_in : r_best_mag;
  assign w_new_bin   = w_take ? r_cnt : r_best_bin;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_end   = 1'b0;
    w_err_early   = 1'b0;
    w_err_missing = 1'b0;
    case (r_state)
      SCAN: begin
        if (mag_valid_in) begin
          if (mag_last_in && w_at_end) begin
            w_frame_end = 1'b1;
          end else if (mag_last_in) begin
            w_err_early = 1'b1;
          end else if (w_at_end) begin
            w_err_missing = 1'b1;
            w_state_nxt   = RESYNC;
          end
        end
      end
      RESYNC: begin
        if (mag_valid_in && mag_last_in) begin
          w_state_nxt = SCAN;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt        <= '0;
      r_thr        <= '0;
      r_best_mag   <= '0;
      r_best_bin   <= '0;
      r_best_valid <= 1'b0;
      r_bin_index  <= '0;
      r_peak_mag   <= '0;
      r_ready      <= 1'b0;
      r_no_peak    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_ready     <= 1'b0;
      r_no_peak   <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_beat) begin
        if (w_first) begin
          r_thr <= threshold_in;
        end
        r_best_valid <= w_new_valid;
        r_best_mag   <= w_new_mag;
        r_best_bin   <= w_new_bin;
        if (w_frame_end) begin
          r_cnt <= '0;
          if (w_new_valid) begin
            r_ready     <= 1'b1;
            r_bin_index <= w_new_bin;
            r_peak_mag  <= w_new_mag;
          end else begin
            r_no_peak <= 1'b1;
          end
        end else if (w_err_early || w_err_missing) begin
          r_cnt       <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + BIN_WIDTH'(1);
        end
      end else if ((r_state == RESYNC) && mag_valid_in && mag_last_in) begin
        r_cnt <= '0;
      end
    end
  end

  assign bin_index_out = r_bin_index;
  assign peak_mag_out  = r_peak_mag;
  assign ready_out     = r_ready;
  assign no_peak_out   = r_no_peak;
  assign frame_err_out = r_frame_err;

endmodule : fft_peak_finder
`default_nettype wire

// File: tb/tb_fft_peak_finder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fft_peak_finder                                              |
// | Purpose  : Directed self-checking bench for fft_peak_finder with a         |
// |            queue of expected output events.                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fft_peak_finder;

  localparam int N     = fft_pkg::FFT_SIZE;
  localparam int MW    = fft_pkg::MAG_WIDTH;
  localparam int BW    = fft_pkg::BIN_WIDTH;
  localparam int MINB  = fft_pkg::MIN_BIN;
  localparam int MAXB  = fft_pkg::MAX_BIN;

  localparam logic [2:0] K_READY  = 3'b100;
  localparam logic [2:0] K_NOPEAK = 3'b010;
  localparam logic [2:0] K_ERR    = 3'b001;

  typedef struct {
    logic [2:0]    kind;
    int            cyc;
    logic [BW-1:0] bin;
    logic [MW-1:0] mag;
  } exp_t;

  logic          clk_in       = 1'b0;
  logic          rst_in       = 1'b0;
  logic [MW-1:0] mag_data_in  = '0;
  logic          mag_valid_in = 1'b0;
  logic          mag_last_in  = 1'b0;
  logic [MW-1:0] threshold_in = '0;
  logic [BW-1:0] bin_index_out;
  logic [MW-1:0] peak_mag_out;
  logic          ready_out;
  logic          no_peak_out;
  logic          frame_err_out;

  fft_peak_finder dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .mag_data_in   (mag_data_in),
    .mag_valid_in  (mag_valid_in),
    .mag_last_in   (mag_last_in),
    .threshold_in  (threshold_in),
    .bin_index_out (bin_index_out),
    .peak_mag_out  (peak_mag_out),
    .ready_out     (ready_out),
    .no_peak_out   (no_peak_out),
    .frame_err_out (frame_err_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int            n_checks = 0;
  int            n_fail   = 0;
  exp_t          q[$];
  logic [MW-1:0] fm[N];
  logic [BW-1:0] held_bin = '0;
  logic [MW-1:0] held_mag = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Output monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk_in) begin : mon
    exp_t e;
    if (rst_in && (ready_out || no_peak_out || frame_err_out)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {61'd0, ready_out, no_peak_out, frame_err_out}, 64'd0);
      end else begin
        e = q.pop_front();
        check("pulse_kind", {61'd0, ready_out, no_peak_out, frame_err_out}, {61'd0, e.kind});
        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
        check("bin_index", 64'(bin_index_out), 64'(e.bin));
        check("peak_mag", 64'(peak_mag_out), 64'(e.mag));
      end
    end
  end

  task automatic beat(input logic [MW-1:0] m, input logic last);
    mag_data_in  = m;
    mag_valid_in = 1'b1;
    mag_last_in  = last;
    @(posedge clk_in);
    #1;
    mag_valid_in = 1'b0;
    mag_last_in  = 1'b0;
    mag_data_in  = $urandom;
  endtask

  task automatic idle();
    mag_valid_in = 1'b0;
    mag_last_in  = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  task automatic fill(input logic [MW-1:0] v);
    for (int b = 0; b < N; b++) fm[b] = v;
  endtask

  task automatic push(input logic [2:0] k, input int c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.bin  = held_bin;
    e.mag  = held_mag;
    q.push_back(e);
  endtask

  // Reference: scan the window, keep first strictly-larger qualifying bin.
  task automatic push_frame_result(input logic [MW-1:0] thr, input int c);
    int            bb;
    logic [MW-1:0] bm;
    bb = -1;
    bm = '0;
    for (int b = MINB; b <= MAXB; b++) begin
      if (fm[b] >= thr && (bb < 0 || fm[b] > bm)) begin
        bb = b;
        bm = fm[b];
      end
    end
    if (bb >= 0) begin
      held_bin = BW'(bb);
      held_mag = bm;
      push(K_READY, c);
    end else begin
      push(K_NOPEAK, c);
    end
  endtask

  // last_at: beat index carrying last (N-1 nominal, smaller = early, <0 = none).
  task automatic run_frame(input int last_at, input logic [MW-1:0] thr, input bit gaps);
    int n;
    n = (last_at < 0) ? N : last_at + 1;
    threshold_in = thr;
    for (int b = 0; b < n; b++) begin
      if (gaps && b != 0) begin
        while ($urandom_range(0, 3) == 0) idle();
      end
      if (b == 1) threshold_in = ~thr;
      if (b == n - 1) begin
        if (last_at == N - 1) push_frame_result(thr, cyc + 1);
        else push(K_ERR, cyc + 1);
      end
      beat(fm[b], b == last_at);
    end
  endtask

  initial begin
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_ready", 64'(ready_out), 64'd0);
    check("rst_no_peak", 64'(no_peak_out), 64'd0);
    check("rst_frame_err", 64'(frame_err_out), 64'd0);
    check("rst_bin", 64'(bin_index_out), 64'd0);
    check("rst_mag", 64'(peak_mag_out), 64'd0);
    rst_in = 1'b1;
    idle();

    // Nominal single peak
    fill(100); fm[107] = 5000;
    run_frame(N - 1, 1000, 0);
    idle();

    // Everything below threshold: status pulse, outputs held
    for (int b = 0; b < N; b++) fm[b] = $urandom_range(0, 500);
    run_frame(N - 1, 1000, 0);

    // Tie keeps lower bin
    fill(10); fm[200] = 7000; fm[300] = 7000;
    run_frame(N - 1, 1000, 0);

    // DC and mirror half excluded
    fill(0); fm[0] = 90000; fm[600] = 80000; fm[40] = 3000;
    run_frame(N - 1, 1000, 0);

    // Window edges: bin MAX_BIN wins over mirror bins and last beat
    fill(0); fm[1] = 5999; fm[MAXB] = 6000; fm[MAXB + 1] = 99999; fm[N - 1] = 99999;
    run_frame(N - 1, 1000, 0);

    // Lowest bin, and magnitude equal to threshold qualifies
    fill(0); fm[0] = 32'hFFFF_FFFF; fm[MINB] = 1000;
    run_frame(N - 1, 1000, 0);

    // Full-width unsigned compare near the top of the range
    fill(0); fm[5] = 32'h8000_0000; fm[6] = 32'hFFFF_FFFE;
    run_frame(N - 1, 32'h7FFF_FFFF, 0);

    // Early last, then a good frame
    fill(50); fm[20] = 4000;
    run_frame(500, 1000, 0);
    fill(50); fm[12] = 4000;
    run_frame(N - 1, 1000, 0);

    // Missing last, resync on next last, then a good frame
    fill(50); fm[33] = 9000;
    run_frame(-1, 1000, 0);
    for (int b = 0; b < 40; b++) beat(32'd77777, 1'b0);
    beat(32'd88888, 1'b1);
    fill(50); fm[300] = 4242;
    run_frame(N - 1, 1000, 0);

    // Back-to-back frames with random gaps
    fill(100); fm[107] = 6000;
    run_frame(N - 1, 1000, 1);
    fill(100); fm[64] = 6500;
    run_frame(N - 1, 1000, 1);
    idle();

    // Async reset mid-frame
    fill(100); fm[250] = 9999;
    threshold_in = 1000;
    for (int b = 0; b < 300; b++) beat(fm[b], 1'b0);
    #2;
    rst_in = 1'b0;
    #1;
    check("arst_ready", 64'(ready_out), 64'd0);
    check("arst_no_peak", 64'(no_peak_out), 64'd0);
    check("arst_frame_err", 64'(frame_err_out), 64'd0);
    check("arst_bin", 64'(bin_index_out), 64'd0);
    check("arst_mag", 64'(peak_mag_out), 64'd0);
    held_bin = '0;
    held_mag = '0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    fill(100); fm[9] = 1234;
    run_frame(N - 1, 1000, 0);

    repeat (3) idle();
    for (int i = 0; i < 20 && q.size() != 0; i++) idle();
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fft_peak_finder
`default_nettype wire
